// File: rtl/chip8_pkg.sv
// Shared CHIP-8 CPU definitions.
//   STACK_BASE_DEF  : byte address of stack slot 0 (0xEA0)
//   STACK_BYTES_DEF : stack window size in bytes (16 entries x 2 bytes)
//   PC_INC          : instruction size, added to PC to form a return address
//   S_*             : stack controller state encoding
//   stack_addr()    : window-relative address, offset wraps inside the window
package chip8_pkg;

  localparam logic [11:0] STACK_BASE_DEF  = 12'hEA0;
  localparam int          STACK_BYTES_DEF = 32;
  localparam logic [15:0] PC_INC          = 16'd2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CALL_HI = 3'd1;
  localparam logic [2:0] S_CALL_LO = 3'd2;
  localparam logic [2:0] S_RET_A   = 3'd3;
  localparam logic [2:0] S_RET_B   = 3'd4;
  localparam logic [2:0] S_RET_C   = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  // mask is STACK_BYTES-1 (window size is a power of two), so the byte
  // offset always lands inside the window even when sp arithmetic wraps.
  function automatic logic [11:0] stack_addr(input logic [11:0] base,
                                             input logic [7:0]  off,
                                             input logic [7:0]  mask);
    return base + {4'h0, off & mask};
  endfunction

endpackage

// File: rtl/cpu_stack_ctrl.sv
// CALL/RET sequencer for the CHIP-8 CPU.
// CALL pushes the return address (PC+2, high byte first) into the stack
// window and loads PC with the target; RET pops the return address into PC.
//
// Build option: STACK_CHECK_EN
//   defined   : overflow, underflow and simultaneous-request checks route to
//               the ERR state (done+err pulse, no writes).
//   undefined : no ERR state, err tied low, CALL wins on simultaneous
//               requests, sp wraps in 8 bits and stack addresses wrap inside
//               the window.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   call_req, ret_req   requests from the decoder, sampled only in IDLE
//   call_addr           CALL target NNN
//   busy, done, err     status; done/err are one-cycle pulses
//   pc_rd, sp_rd        current PC / SP (byte offset) from the register file
//   pc_en/pc_wr         PC write port
//   sp_en/sp_wr         SP write port
//   mem_addr, mem_we,   RAM port; mem_rdata is valid one cycle after
//   mem_wdata, mem_rdata  mem_addr
module cpu_stack_ctrl
  import chip8_pkg::*;
#(
  parameter logic [11:0] STACK_BASE  = STACK_BASE_DEF,
  parameter int          STACK_BYTES = STACK_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic [11:0] call_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [15:0] pc_rd,
  input  logic [7:0]  sp_rd,
  output logic        pc_en,
  output logic [15:0] pc_wr,
  output logic        sp_en,
  output logic [7:0]  sp_wr,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [7:0] OFF_MASK = 8'(STACK_BYTES - 1);
`ifdef STACK_CHECK_EN
  localparam logic [7:0] SP_MAX   = 8'(STACK_BYTES - 2);
`endif

  logic [2:0]  state;
  logic [7:0]  sp;    // sp_rd captured at acceptance
  logic [15:0] ra;    // return address to push
  logic [11:0] tgt;   // CALL target
  logic [7:0]  hi;    // popped high byte

  // ---------------------------------------------------------------------
  // State and operand registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sp    <= '0;
      ra    <= '0;
      tgt   <= '0;
      hi    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
`ifdef STACK_CHECK_EN
          if (call_req && ret_req) begin
            state <= S_ERR;
          end else if (call_req) begin
            if (sp_rd <= SP_MAX) begin
              sp    <= sp_rd;
              ra    <= pc_rd + PC_INC;
              tgt   <= call_addr;
              state <= S_CALL_HI;
            end else begin
              state <= S_ERR;
            end
          end else if (ret_req) begin
            if (sp_rd >= 8'd2) begin
              sp    <= sp_rd;
              state <= S_RET_A;
            end else begin
              state <= S_ERR;
            end
          end
`else
          if (call_req) begin
            sp    <= sp_rd;
            ra    <= pc_rd + PC_INC;
            tgt   <= call_addr;
            state <= S_CALL_HI;
          end else if (ret_req) begin
            sp    <= sp_rd;
            state <= S_RET_A;
          end
`endif
        end
        S_CALL_HI: state <= S_CALL_LO;
        S_CALL_LO: state <= S_IDLE;
        S_RET_A:   state <= S_RET_B;
        S_RET_B: begin
          // data for the RET_A address arrives now
          hi    <= mem_rdata;
          state <= S_RET_C;
        end
        S_RET_C:   state <= S_IDLE;
`ifdef STACK_CHECK_EN
        S_ERR:     state <= S_IDLE;
`endif
        default:   state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs decoded from registered state. The only input used is
  // mem_rdata in RET_C (low byte of the popped address); request inputs
  // never reach the strobes directly.
  // ---------------------------------------------------------------------
  always_comb begin
    busy      = (state != S_IDLE);
    done      = 1'b0;
    err       = 1'b0;
    pc_en     = 1'b0;
    pc_wr     = '0;
    sp_en     = 1'b0;
    sp_wr     = '0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      S_CALL_HI: begin
        mem_we    = 1'b1;
        mem_addr  = stack_addr(STACK_BASE, sp, OFF_MASK);
        mem_wdata = ra[15:8];
      end
      S_CALL_LO: begin
        mem_we    = 1'b1;
        mem_addr  = stack_addr(STACK_BASE, sp + 8'd1, OFF_MASK);
        mem_wdata = ra[7:0];
        pc_en     = 1'b1;
        pc_wr     = {4'h0, tgt};
        sp_en     = 1'b1;
        sp_wr     = sp + 8'd2;
        done      = 1'b1;
      end
      S_RET_A: mem_addr = stack_addr(STACK_BASE, sp - 8'd2, OFF_MASK);
      S_RET_B: mem_addr = stack_addr(STACK_BASE, sp - 8'd1, OFF_MASK);
      S_RET_C: begin
        pc_en = 1'b1;
        pc_wr = {hi, mem_rdata};
        sp_en = 1'b1;
        sp_wr = sp - 8'd2;
        done  = 1'b1;
      end
`ifdef STACK_CHECK_EN
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_stack_ctrl.sv
// Self-checking bench for cpu_stack_ctrl. The bench plays register file and
// RAM; a behavioural model (byte array + pc/sp integers) predicts each
// operation's outcome. Works with STACK_CHECK_EN defined or undefined.
module tb_cpu_stack_ctrl;
  import chip8_pkg::*;

  localparam int BASE = 'hEA0;

  logic        clk = 1'b0;
  logic        rst;
  logic        call_req, ret_req;
  logic [11:0] call_addr;
  logic        busy, done, err;
  logic [15:0] pc_rd;
  logic [7:0]  sp_rd;
  logic        pc_en, sp_en, mem_we;
  logic [15:0] pc_wr;
  logic [7:0]  sp_wr, mem_wdata;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  cpu_stack_ctrl dut (
    .clk(clk), .rst(rst),
    .call_req(call_req), .ret_req(ret_req), .call_addr(call_addr),
    .busy(busy), .done(done), .err(err),
    .pc_rd(pc_rd), .sp_rd(sp_rd),
    .pc_en(pc_en), .pc_wr(pc_wr), .sp_en(sp_en), .sp_wr(sp_wr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // ---------------- environment: register file + RAM ----------------
  logic [7:0]  ram [0:4095];
  logic [15:0] pc_reg = 16'h0;
  logic [7:0]  sp_reg = 8'h0;
  logic        env_load = 1'b0, env_clear = 1'b0;
  logic [15:0] env_pc = 16'h0;
  logic [7:0]  env_sp = 8'h0;
  int n_we = 0, n_pc = 0, n_sp = 0, n_err = 0;

  assign pc_rd = pc_reg;
  assign sp_rd = sp_reg;

  always @(posedge clk) begin
    if (env_load) begin
      pc_reg <= env_pc;
      sp_reg <= env_sp;
    end else begin
      if (pc_en) pc_reg <= pc_wr;
      if (sp_en) sp_reg <= sp_wr;
    end
    if (env_clear) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
    if (mem_we) n_we  <= n_we + 1;
    if (pc_en)  n_pc  <= n_pc + 1;
    if (sp_en)  n_sp  <= n_sp + 1;
    if (err)    n_err <= n_err + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0] model_ram [0:4095];
  int         model_pc, model_sp;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic env_set(input int pc, input int sp);
    env_pc = 16'(pc);
    env_sp = 8'(sp);
    env_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    env_load = 1'b0;
    model_pc = pc & 'hFFFF;
    model_sp = sp & 'hFF;
  endtask

  // One decoder transaction: predict, drive, hold until done, then compare.
  task automatic run_op(input bit c, input bit r, input logic [11:0] a, input string tag);
    int  s, lat_exp, lat_obs, we_exp, upd_exp, we0, pc0, sp0, err0, bad, ra;
    bit  e_err;
    logic err_seen;
    s = model_sp;
    e_err = 1'b0;
`ifdef STACK_CHECK_EN
    if (c && r)                               e_err = 1'b1;
    else if (c && s > STACK_BYTES_DEF - 2)    e_err = 1'b1;
    else if (!c && r && s < 2)                e_err = 1'b1;
`endif
    lat_exp = 0; we_exp = 0; upd_exp = 0;
    if (e_err) begin
      lat_exp = 1;
    end else if (c) begin
      ra = (model_pc + 2) & 'hFFFF;
      model_ram[BASE + (s % 32)]       = 8'(ra >> 8);
      model_ram[BASE + ((s + 1) % 32)] = 8'(ra);
      model_pc = a;
      model_sp = (s + 2) % 256;
      lat_exp = 2; we_exp = 2; upd_exp = 1;
    end else if (r) begin
      model_pc = {model_ram[BASE + ((s + 254) % 32)], model_ram[BASE + ((s + 255) % 32)]};
      model_sp = (s + 254) % 256;
      lat_exp = 3; upd_exp = 1;
    end

    we0 = n_we; pc0 = n_pc; sp0 = n_sp; err0 = n_err;
    call_req = c; ret_req = r; call_addr = a;
    @(posedge clk);
    lat_obs = 0;
    err_seen = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, " busy"}, busy, 1);
      if (done) begin
        lat_obs = k;
        err_seen = err;
        break;
      end
    end
    call_req = 1'b0;
    ret_req = 1'b0;
    chk({tag, " done latency"}, lat_obs, lat_exp);
    chk({tag, " err"}, err_seen, e_err);
    @(negedge clk);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " pc"}, pc_reg, model_pc);
    chk({tag, " sp"}, sp_reg, model_sp);
    chk({tag, " ram writes"}, n_we - we0, we_exp);
    chk({tag, " pc writes"}, n_pc - pc0, upd_exp);
    chk({tag, " sp writes"}, n_sp - sp0, upd_exp);
    chk({tag, " err pulses"}, n_err - err0, e_err);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (ram[BASE + i] !== model_ram[BASE + i]) bad++;
    chk({tag, " stack bytes"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, sp_r;
    call_req = 1'b0; ret_req = 1'b0; call_addr = '0;
    for (int i = 0; i < 4096; i++) model_ram[i] = 8'h00;

    // reset
    rst = 1'b1;
    env_pc = 16'h0200; env_sp = 8'h00; env_load = 1'b1; env_clear = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done/err", {done, err}, 0);
    chk("reset strobes", {pc_en, sp_en, mem_we}, 0);
    chk("reset pc_wr", pc_wr, 0);
    chk("reset sp_wr", sp_wr, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    rst = 1'b0; env_load = 1'b0; env_clear = 1'b0;
    model_pc = 'h0200; model_sp = 0;
    @(negedge clk);

    // basic CALL / RET
    run_op(1'b1, 1'b0, 12'h345, "call basic");
    chk("call basic ram EA0", ram[12'hEA0], 8'h02);
    chk("call basic ram EA1", ram[12'hEA1], 8'h02);
    chk("call basic pc", pc_reg, 16'h0345);
    chk("call basic sp", sp_reg, 8'd2);
    run_op(1'b0, 1'b1, 12'h000, "ret basic");
    chk("ret basic pc", pc_reg, 16'h0202);
    chk("ret basic sp", sp_reg, 8'd0);

    // nesting to full depth, then one more
    for (int i = 0; i < 16; i++) run_op(1'b1, 1'b0, 12'(12'h100 + i * 16), "nest call");
    chk("nest depth sp", sp_reg, 8'd32);
    run_op(1'b1, 1'b0, 12'hABC, "call 17th");
    for (int i = 0; i < 16; i++) run_op(1'b0, 1'b1, 12'h000, "nest ret");

    // underflow and conflict
    env_set('h0400, 0);
    run_op(1'b0, 1'b1, 12'h000, "ret at sp0");
    env_set('h0410, 4);
    run_op(1'b1, 1'b1, 12'h222, "call+ret");

    // reset while in CALL_HI
    env_set('h0300, 4);
    call_req = 1'b1; call_addr = 12'h111;
    @(posedge clk);
    @(negedge clk);
    chk("midreset busy before", busy, 1);
    chk("midreset addr before", mem_addr, 12'hEA4);
    rst = 1'b1; call_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ram[BASE + 4] = 8'h03;  // high byte of 0x0302 lands before reset
    chk("midreset busy", busy, 0);
    chk("midreset strobes", {pc_en, sp_en, mem_we, done}, 0);
    chk("midreset pc kept", pc_reg, 16'h0300);
    chk("midreset sp kept", sp_reg, 8'd4);

    // top of window, then one past it
    env_set('h0500, 30);
    run_op(1'b1, 1'b0, 12'h600, "call sp30");
    chk("call sp30 ram EBE", ram[12'hEBE], 8'h05);
    chk("call sp30 ram EBF", ram[12'hEBF], 8'h02);
    chk("call sp30 sp", sp_reg, 8'd32);
    run_op(1'b1, 1'b0, 12'h700, "call sp32");
`ifndef STACK_CHECK_EN
    chk("wrap ram EA0", ram[12'hEA0], 8'h06);
    chk("wrap ram EA1", ram[12'hEA1], 8'h02);
`endif

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
`ifdef STACK_CHECK_EN
        sp_r = int'($urandom_range(0, 17)) * 2;
`else
        sp_r = int'($urandom_range(0, 255));
`endif
        env_set(int'($urandom_range(0, 65535)), sp_r);
      end
      op = int'($urandom_range(0, 9));
      if (op < 5)      run_op(1'b1, 1'b0, 12'($urandom), "rand call");
      else if (op < 9) run_op(1'b0, 1'b1, 12'($urandom), "rand ret");
      else             run_op(1'b1, 1'b1, 12'($urandom), "rand both");
    end

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
